// File: rtl/mem_latency_ctrl.sv
// Word-array memory that completes each CPU read/write a fixed LATENCY edges after acceptance.
// One request in flight at a time; completion is a one-cycle mem_ready pulse and requests are ignored until IDLE.
module mem_latency_ctrl #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 readM,
    input  logic                 writeM,
    input  logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    output logic                 mem_ready,
    output logic                 busy,
    output logic [WORD_SIZE-1:0] access_count,
    output logic                 err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [3:0]             cnt;
    logic [3:0]             cnt_nxt;
    logic                   op_wr;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [WORD_SIZE-1:0]   wdata_q;
    logic [WORD_SIZE-1:0]   rdata;
    logic                   accept;
    logic                   conflict;
    logic                   finish;
    logic                   unused_addr_bits;

    logic [WORD_SIZE-1:0]   mem [2**ADDR_BITS];

    assign accept           = (state == IDLE) && (readM ^ writeM);
    assign conflict         = (state == IDLE) && readM && writeM;
    assign finish           = (state == BUSY) && (cnt == 4'd0);
    assign busy             = (state != IDLE);
    assign data             = readM ? rdata : {WORD_SIZE{1'bz}};
    assign unused_addr_bits = ^address[WORD_SIZE-1:ADDR_BITS];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            op_wr        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata        <= '0;
            mem_ready    <= 1'b0;
            access_count <= '0;
            err          <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mem_ready <= finish;
            if (accept) begin
                op_wr  <= writeM;
                addr_q <= address[ADDR_BITS-1:0];
                if (writeM) begin
                    wdata_q <= data;
                end
            end
            if (finish) begin
                access_count <= access_count + 1'b1;
                if (!op_wr) begin
                    rdata <= mem[addr_q];
                end
            end
            if (conflict) begin
                err <= 1'b1;
            end
        end
    end

    // Array has no reset: contents survive reset, and an aborted write never reaches it
    // because reset forces state out of BUSY before its completion edge.
    always_ff @(posedge clk) begin
        if (finish && op_wr) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_latency_ctrl.sv
// Bench for mem_latency_ctrl: a LATENCY=4 instance and a narrow LATENCY=1 instance for counter wrap.
module tb_mem_latency_ctrl;

    typedef struct {
        logic        is_read;
        logic [15:0] rdata;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [1:0]  rdm;
    logic [1:0]  wrm;
    logic [15:0] adr  [2];
    logic [15:0] wdat [2];

    wire [15:0] d0;
    wire [7:0]  d1;
    wire        rdy0, rdy1, bsy0, bsy1, err0, err1;
    wire [15:0] cnt0;
    wire [7:0]  cnt1;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   exp_cnt [2];
    exp_t q0[$];
    exp_t q1[$];

    assign d0 = rdm[0] ? 16'hzzzz : wdat[0];
    assign d1 = rdm[1] ? 8'hzz : wdat[1][7:0];

    mem_latency_ctrl #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(4)) u0 (
        .clk(clk), .reset(reset), .readM(rdm[0]), .writeM(wrm[0]), .address(adr[0]),
        .data(d0), .mem_ready(rdy0), .busy(bsy0), .access_count(cnt0), .err(err0)
    );

    mem_latency_ctrl #(.WORD_SIZE(8), .ADDR_BITS(4), .LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .readM(rdm[1]), .writeM(wrm[1]), .address(adr[1][7:0]),
        .data(d1), .mem_ready(rdy1), .busy(bsy1), .access_count(cnt1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic g_rdy(int d);
        return (d == 1) ? rdy1 : rdy0;
    endfunction
    function automatic logic g_busy(int d);
        return (d == 1) ? bsy1 : bsy0;
    endfunction
    function automatic logic g_err(int d);
        return (d == 1) ? err1 : err0;
    endfunction
    function automatic logic [15:0] g_cnt(int d);
        return (d == 1) ? {8'h00, cnt1} : cnt0;
    endfunction
    function automatic logic [15:0] g_data(int d);
        return (d == 1) ? {8'h00, d1} : d0;
    endfunction
    function automatic int lat(int d);
        return (d == 1) ? 1 : 4;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: every mem_ready pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (g_rdy(d)) begin
                exp_t e;
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ready dut=%0d actual=1 required=0 (t=%0t)", d, $time);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("ready_cycle%0d", d), 16'(cyc), 16'(e.cyc));
                    chk($sformatf("access_count%0d", d), g_cnt(d), e.cnt);
                    if (e.is_read) chk($sformatf("read_data%0d", d), g_data(d), e.rdata);
                end
            end
        end
    end

    task automatic access(input int d, input bit is_rd, input logic [15:0] a,
                          input logic [15:0] wd, input logic [15:0] exp_rd, input bit mid);
        exp_t e;
        bit   got;
        rdm[d]  = is_rd;
        wrm[d]  = !is_rd;
        adr[d]  = a;
        wdat[d] = wd;
        @(posedge clk);
        #1;
        exp_cnt[d] = (exp_cnt[d] + 1) & ((d == 1) ? 32'hFF : 32'hFFFF);
        e.is_read = is_rd;
        e.rdata   = exp_rd;
        e.cnt     = 16'(exp_cnt[d]);
        e.cyc     = cyc + lat(d);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        chk("busy_after_accept", 16'(g_busy(d)), 16'd1);
        if (mid) begin
            @(posedge clk);
            #1;
            adr[d]  = 16'h0007;
            wdat[d] = 16'hFFFF;
        end
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (g_rdy(d)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout dut=%0d actual=0 required=1", d);
        end
        chk("busy_in_done", 16'(g_busy(d)), 16'd1);
        @(posedge clk);
        #1;
        rdm[d] = 1'b0;
        wrm[d] = 1'b0;
        chk("busy_after_done", 16'(g_busy(d)), 16'd0);
        chk("ready_one_cycle", 16'(g_rdy(d)), 16'd0);
    endtask

    initial begin
        reset   = 1'b1;
        rdm     = 2'b00;
        wrm     = 2'b00;
        adr[0]  = 16'h0;
        adr[1]  = 16'h0;
        wdat[0] = 16'h0;
        wdat[1] = 16'h0;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 16'(rdy0), 16'd0);
        chk("rst_busy", 16'(bsy0), 16'd0);
        chk("rst_count", cnt0, 16'h0000);
        chk("rst_err", 16'(err0), 16'd0);
        chk("rst_count1", {8'h00, cnt1}, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        access(0, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
        chk("err_after_write", 16'(err0), 16'd0);
        access(0, 1'b1, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
        wdat[0] = 16'h5A5A;
        #1;
        chk("data_released", d0, 16'h5A5A);

        access(0, 1'b0, 16'h0007, 16'h7777, 16'h0000, 1'b0);
        access(0, 1'b0, 16'h0105, 16'h1234, 16'h0000, 1'b1);
        access(0, 1'b1, 16'h0005, 16'h0000, 16'h1234, 1'b0);
        access(0, 1'b1, 16'h0007, 16'h0000, 16'h7777, 1'b0);

        rdm[0]  = 1'b1;
        wrm[0]  = 1'b1;
        adr[0]  = 16'h0010;
        wdat[0] = 16'h0000;
        @(posedge clk);
        #1;
        chk("conflict_err", 16'(err0), 16'd1);
        chk("conflict_busy", 16'(bsy0), 16'd0);
        rdm[0] = 1'b0;
        wrm[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("conflict_idle", 16'(bsy0), 16'd0);
        chk("conflict_count", cnt0, 16'(exp_cnt[0]));
        access(0, 1'b1, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
        chk("err_sticky", 16'(err0), 16'd1);

        access(0, 1'b0, 16'h0020, 16'h1111, 16'h0000, 1'b0);
        wrm[0]  = 1'b1;
        adr[0]  = 16'h0020;
        wdat[0] = 16'hAAAA;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b1;
        wrm[0] = 1'b0;
        #1;
        chk("abort_ready", 16'(rdy0), 16'd0);
        chk("abort_busy", 16'(bsy0), 16'd0);
        chk("abort_count", cnt0, 16'h0000);
        chk("abort_err", 16'(err0), 16'd0);
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        @(negedge clk);
        reset = 1'b0;
        access(0, 1'b1, 16'h0020, 16'h0000, 16'h1111, 1'b0);

        access(1, 1'b0, 16'h0003, 16'h005C, 16'h0000, 1'b0);
        access(1, 1'b1, 16'h0003, 16'h0000, 16'h005C, 1'b0);
        for (int i = 0; i < 255; i++) begin
            access(1, 1'b0, 16'(i & 15), 16'(i & 255), 16'h0000, 1'b0);
        end
        chk("wrapped_count1", {8'h00, cnt1}, 16'h0001);
        access(1, 1'b1, 16'h000E, 16'h0000, 16'h00FE, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue0_drained", 16'(q0.size()), 16'd0);
        chk("queue1_drained", 16'(q1.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
